// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between three requesters and schedules
// refresh (hinted or forced). One command or refresh is in flight at a time.
module sdram_arbiter #(
  parameter int ADDR_BITS        = 22,
  parameter int DATA_BITS        = 16,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req,
  input  logic [2:0]             we,
  input  logic [3*ADDR_BITS-1:0] addr,
  input  logic [3*DATA_BITS-1:0] wdata,
  output logic [2:0]             ack,
  output logic [DATA_BITS-1:0]   rdata,
  input  logic                   refresh_hint,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [DATA_BITS-1:0]   mem_wdata,
  output logic                   mem_refresh,
  input  logic                   mem_ack,
  input  logic [DATA_BITS-1:0]   mem_rdata
);
  localparam logic [15:0] CNT_MAX = 16'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REFRESH} state_e;

  state_e               state_q;
  logic [2:0]           slot_vld_q, slot_vld_d;
  logic [2:0]           slot_we_q;
  logic [ADDR_BITS-1:0] slot_addr_q  [3];
  logic [DATA_BITS-1:0] slot_wdata_q [3];
  logic                 ref_pend_q, ref_pend_d;
  logic [15:0]          ref_cnt_q, ref_cnt_d;
  logic [1:0]           gnt_port_q;
  logic [2:0]           ack_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 mem_req_q, mem_refresh_q, mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_q;

  logic                 gnt_ref;
  logic [2:0]           gnt_vec;
  logic [1:0]           gnt_idx;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

  // Fixed priority in IDLE: pending refresh, then port 0, 1, 2.
  always_comb begin
    gnt_ref = (state_q == S_IDLE) && ref_pend_q;
    gnt_vec = 3'b000;
    gnt_idx = 2'd0;
    if ((state_q == S_IDLE) && !ref_pend_q) begin
      if (slot_vld_q[0]) begin
        gnt_vec = 3'b001;
        gnt_idx = 2'd0;
      end else if (slot_vld_q[1]) begin
        gnt_vec = 3'b010;
        gnt_idx = 2'd1;
      end else if (slot_vld_q[2]) begin
        gnt_vec = 3'b100;
        gnt_idx = 2'd2;
      end
    end
    case (gnt_idx)
      2'd1: begin
        sel_we    = slot_we_q[1];
        sel_addr  = slot_addr_q[1];
        sel_wdata = slot_wdata_q[1];
      end
      2'd2: begin
        sel_we    = slot_we_q[2];
        sel_addr  = slot_addr_q[2];
        sel_wdata = slot_wdata_q[2];
      end
      default: begin
        sel_we    = slot_we_q[0];
        sel_addr  = slot_addr_q[0];
        sel_wdata = slot_wdata_q[0];
      end
    endcase
  end

  // A req in the grant cycle reloads the slot, so req wins over the grant clear.
  always_comb begin
    slot_vld_d = (slot_vld_q & ~gnt_vec) | req;
    if (gnt_ref) begin
      ref_cnt_d = 16'd0;
    end else if (ref_cnt_q >= CNT_MAX) begin
      ref_cnt_d = CNT_MAX;
    end else begin
      ref_cnt_d = ref_cnt_q + 16'd1;
    end
    if (gnt_ref) begin
      ref_pend_d = 1'b0;
    end else begin
      ref_pend_d = ref_pend_q | refresh_hint | (ref_cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        slot_we_q[i]    <= we[i];
        slot_addr_q[i]  <= addr[i*ADDR_BITS +: ADDR_BITS];
        slot_wdata_q[i] <= wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      slot_vld_q    <= 3'b000;
      ref_pend_q    <= 1'b0;
      ref_cnt_q     <= 16'd0;
      gnt_port_q    <= 2'd0;
      ack_q         <= 3'b000;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      slot_vld_q    <= slot_vld_d;
      ref_pend_q    <= ref_pend_d;
      ref_cnt_q     <= ref_cnt_d;
      ack_q         <= 3'b000;
      mem_req_q     <= 1'b0;
      mem_refresh_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_ref) begin
            mem_refresh_q <= 1'b1;
            state_q       <= S_REFRESH;
          end else if (gnt_vec != 3'b000) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            gnt_port_q  <= gnt_idx;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            ack_q   <= 3'b001 << gnt_port_q;
            state_q <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (mem_ack) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic, compared every cycle
// against a transaction-level model of slots, in-flight command and refresh deadline.
module tb_sdram_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int RI = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]    ack;
  logic [DW-1:0] rdata;
  logic          refresh_hint = 1'b0;
  logic          mem_req, mem_we, mem_refresh;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .refresh_hint(refresh_hint), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_refresh(mem_refresh), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending commands per port, what is in flight (-1 none,
  // 0..2 a port, 3 a refresh), and the refresh deadline measured in edges.
  bit            m_vld [3];
  bit            m_we  [3];
  logic [AW-1:0] m_addr[3];
  logic [DW-1:0] m_wd  [3];
  int            m_busy;
  bit            m_pend;
  int            m_edge, m_last_ref;
  logic [2:0]    e_ack;
  logic [DW-1:0] e_rdata;
  bit            e_req, e_ref, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic model_reset();
    for (int p = 0; p < 3; p++) m_vld[p] = 1'b0;
    m_busy = -1; m_pend = 1'b0; m_edge = 0; m_last_ref = 0;
    e_ack = '0; e_rdata = '0; e_req = 1'b0; e_ref = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_edge();
    int g;
    bit gref;
    m_edge++;
    g = -1; gref = 1'b0;
    e_req = 1'b0; e_ref = 1'b0; e_ack = '0;
    if (m_busy < 0) begin
      if (m_pend) gref = 1'b1;
      else for (int p = 0; p < 3; p++) if (m_vld[p] && g < 0) g = p;
    end else if (mem_ack) begin
      if (m_busy < 3) begin
        e_ack = 3'b001 << m_busy;
        if (!e_we) e_rdata = mem_rdata;
      end
      m_busy = -1;
    end
    if (gref) begin
      e_ref = 1'b1; m_busy = 3; m_pend = 1'b0; m_last_ref = m_edge;
    end else begin
      m_pend = m_pend | refresh_hint | ((m_edge - m_last_ref) >= RI - 1);
    end
    if (g >= 0) begin
      e_req = 1'b1; e_we = m_we[g]; e_addr = m_addr[g]; e_wdata = m_wd[g]; m_busy = g;
    end
    for (int p = 0; p < 3; p++) begin
      if (req[p]) begin
        m_vld[p] = 1'b1; m_we[p] = we[p];
        m_addr[p] = addr[p*AW +: AW]; m_wd[p] = wdata[p*DW +: DW];
      end else if (g == p) begin
        m_vld[p] = 1'b0;
      end
    end
  endtask

  int            cyc = 0;
  int            cd = 0;
  int            lat_fix = 0;
  bit            rd_fix_en = 1'b0;
  logic [DW-1:0] rd_fix = '0;
  int            ev[$];
  int            ref_cyc[$];
  int            req_addr[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_refresh", 32'(mem_refresh), 32'(e_ref));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (mem_refresh) begin ev.push_back(3); ref_cyc.push_back(cyc); end
    if (mem_req) begin ev.push_back(4); req_addr.push_back(int'(mem_addr)); end
    for (int p = 0; p < 3; p++) if (ack[p]) ev.push_back(10 + p);
    if (mem_req || mem_refresh) cd = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
    req = '0;
    refresh_hint = 1'b0;
    mem_ack = (cd == 1);
    if (cd > 0) cd--;
    mem_rdata = rd_fix_en ? rd_fix : DW'($urandom);
  endtask

  task automatic put(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = 1'b1;
    we[p] = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_refresh", 32'(mem_refresh), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    req = '0; refresh_hint = 1'b0; mem_ack = 1'b0; cd = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int c0;
    int ak[$];
    model_reset();
    #1;

    // Single port 0 read with a 5-cycle controller latency.
    do_reset();
    lat_fix = 5; rd_fix_en = 1'b1; rd_fix = 16'hBEEF;
    put(0, 1'b0, 22'h001234, 16'h0);
    step();
    step();
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h001234);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    repeat (5) step();
    chk("t1_ack", 32'(ack), 32'b001);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    rd_fix_en = 1'b0;

    // All three ports at once: served and acked in order 0, 1, 2.
    do_reset();
    lat_fix = 3; ev.delete();
    put(0, 1'b0, 22'h000100, 16'h0);
    put(1, 1'b1, 22'h000200, 16'h1111);
    put(2, 1'b0, 22'h000300, 16'h0);
    repeat (14) step();
    ak.delete();
    foreach (ev[i]) if (ev[i] >= 10) ak.push_back(ev[i]);
    chk("t2_ack_count", 32'(ak.size()), 32'd3);
    for (int i = 0; i < ak.size() && i < 3; i++) chk("t2_ack_order", 32'(ak[i]), 32'(10 + i));

    // Port 1 request replaced while port 0 is busy: only the newest is issued.
    do_reset();
    lat_fix = 4; ev.delete(); req_addr.delete();
    put(0, 1'b0, 22'h001234, 16'h0);
    step();
    put(1, 1'b0, 22'h000010, 16'h0);
    step();
    put(1, 1'b0, 22'h000020, 16'h0);
    repeat (12) step();
    chk("t3_req_count", 32'(req_addr.size()), 32'd2);
    if (req_addr.size() == 2) chk("t3_newest_addr", 32'(req_addr[1]), 32'h20);
    ak.delete();
    foreach (ev[i]) if (ev[i] == 11) ak.push_back(ev[i]);
    chk("t3_ack1_count", 32'(ak.size()), 32'd1);

    // Hint during a port 2 write with port 0 waiting: refresh goes before port 0.
    do_reset();
    lat_fix = 5; ev.delete();
    put(2, 1'b1, 22'h0000AA, 16'h5A5A);
    step();
    step();
    refresh_hint = 1'b1;
    put(0, 1'b0, 22'h0000BB, 16'h0);
    repeat (18) step();
    chk("t4_event_count", 32'(ev.size()), 32'd5);
    if (ev.size() == 5) begin
      chk("t4_ev0_write_req", 32'(ev[0]), 32'd4);
      chk("t4_ev1_ack2", 32'(ev[1]), 32'd12);
      chk("t4_ev2_refresh", 32'(ev[2]), 32'd3);
      chk("t4_ev3_port0_req", 32'(ev[3]), 32'd4);
      chk("t4_ev4_ack0", 32'(ev[4]), 32'd10);
    end

    // Idle ports, no hints: forced refresh every RI cycles.
    do_reset();
    lat_fix = 2; ref_cyc.delete();
    c0 = cyc;
    repeat (60) step();
    chk("t5_refresh_count", 32'(ref_cyc.size()), 32'd3);
    if (ref_cyc.size() == 3) begin
      chk("t5_first_refresh", 32'(ref_cyc[0] - c0), 32'(RI));
      for (int i = 1; i < 3; i++) chk("t5_interval", 32'(ref_cyc[i] - ref_cyc[i-1]), 32'(RI));
    end

    // Reset while busy, then a stray mem_ack, then normal service.
    do_reset();
    lat_fix = 5;
    put(0, 1'b0, 22'h000777, 16'h0);
    step();
    step();
    step();
    do_reset();
    mem_ack = 1'b1;
    step();
    step();
    chk("t6_no_stray_ack", 32'(ack), 32'd0);
    put(0, 1'b0, 22'h000055, 16'h0);
    step();
    step();
    chk("t6_mem_req", 32'(mem_req), 32'd1);
    chk("t6_mem_addr", 32'(mem_addr), 32'h55);
    repeat (8) step();

    // Random traffic with random latency, hints, stray acks and one mid-run reset.
    do_reset();
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 5) == 0) put(p, 1'($urandom), AW'($urandom), DW'($urandom));
      end
      if ($urandom_range(0, 19) == 0) refresh_hint = 1'b1;
      if (cd == 0 && m_busy < 0 && $urandom_range(0, 29) == 0) mem_ack = 1'b1;
      if (i == 1500) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
